id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined MIPS core. It sits directly downstream of the decode-stage control unit and register file. Each cycle it captures the decoded control bundle, operands, immediate and register indices into the EX stage. It also contains the load-use and jr hazard detector, which stalls PC and IF/ID and inserts bubbles into EX.

---
 rtl/mips_pipe_pkg.sv | 62 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 67 ++++++
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the pipelined MIPS core's ID/EX slice.
//   - CTRL_W and the bit position of every field in the 15-bit control bundle
//     {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchNE,BranchEQ,
//      Jump,Jal,Jr,ALUOp[3:0]} (MSB first)
//   - ALUOp codes as an enum
//   - REG_RA, the link register written by jal
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int CTRL_W = 15;

  // Control bundle bit positions
  localparam int CTRL_REGDST   = 14;
  localparam int CTRL_ALUSRC   = 13;
  localparam int CTRL_MEMTOREG = 12;
  localparam int CTRL_REGWRITE = 11;
  localparam int CTRL_MEMREAD  = 10;
  localparam int CTRL_MEMWRITE = 9;
  localparam int CTRL_BRANCHNE = 8;
  localparam int CTRL_BRANCHEQ = 7;
  localparam int CTRL_JUMP     = 6;
  localparam int CTRL_JAL      = 5;
  localparam int CTRL_JR       = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic [3:0] {
    ALUOP_DEFAULT = 4'd0,
    ALUOP_ADDI    = 4'd1,
    ALUOP_ORI     = 4'd2,
    ALUOP_ANDI    = 4'd3,
    ALUOP_LUI     = 4'd4,
    ALUOP_SW      = 4'd5,
    ALUOP_LW      = 4'd6,
    ALUOP_BEQ     = 4'd7,
    ALUOP_BNE     = 4'd8,
    ALUOP_J       = 4'd9,
    ALUOP_JAL     = 4'd10,
    ALUOP_RTYPE   = 4'd15
  } alu_op_e;

  // Same layout as the packed control vector, for readable field access
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch_ne;
    logic    branch_eq;
    logic    jump;
    logic    jal;
    logic    jr;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int REG_RA = 31;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use and jr hazard detection for the ID/EX stage.
// Ports:
//   id_regdst/id_memwrite/id_branch_eq/id_branch_ne/id_jump/id_jal/id_jr
//                          decoded control bits of the instruction in ID
//   id_rs, id_rt           source register indices in ID
//   ex_valid               EX holds a real instruction
//   ex_regdst/ex_regwrite/ex_memread/ex_jal  control bits of the EX instruction
//   ex_rt, ex_rd           register indices of the EX instruction
//   mem_regwrite, mem_wreg register-file write of the instruction in MEM
//   load_use               ID needs a value still being loaded in EX
//   jr_hazard              jr in ID needs a value not yet written back
// ---------------------------------------------------------------------------
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_regdst,
  input  logic             id_memwrite,
  input  logic             id_branch_eq,
  input  logic             id_branch_ne,
  input  logic             id_jump,
  input  logic             id_jal,
  input  logic             id_jr,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_valid,
  input  logic             ex_regdst,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_jal,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_wreg,
  output logic             load_use,
  output logic             jr_hazard
);

  logic             uses_rs;
  logic             uses_rt;
  logic [REG_W-1:0] ex_wreg;
  logic             rs_nonzero;

  // j/jal take no register source; only R-type, stores and branches read rt
  assign uses_rs = !(id_jump || id_jal);
  assign uses_rt = id_regdst || id_memwrite || id_branch_eq || id_branch_ne;

  assign ex_wreg = ex_regdst ? ex_rd :
                   ex_jal    ? REG_W'(REG_RA) :
                               ex_rt;

  // $0 is hardwired, so a write to it never creates a dependency
  assign rs_nonzero = (id_rs != '0);

  assign load_use = ex_valid && ex_memread && (ex_rt != '0) &&
                    ((uses_rs && (ex_rt == id_rs)) ||
                     (uses_rt && (ex_rt == id_rt)));

  // jr reads rs in ID with no forwarding, so it waits on producers in EX and MEM
  assign jr_hazard = id_jr && rs_nonzero &&
                     ((ex_valid && ex_regwrite && (ex_wreg == id_rs)) ||
                      (mem_regwrite && (mem_wreg == id_rs)));

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the pipelined MIPS core with load-use / jr
// stall generation and an optional stall-cycle counter.
// Optional feature macro: STALL_COUNTER_EN (builds the saturating counter;
// when undefined stall_count is tied to 0).
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   flush                  kill the ID instruction (becomes a bubble)
//   id_valid, id_ctrl      ID instruction valid and its control bundle
//   id_pc4/rd1/rd2/imm     ID data fields
//   id_rs/rt/rd            ID register indices
//   mem_regwrite, mem_wreg MEM-stage register write
//   ex_*                   registered copies of the ID fields
//   stall                  combinational: hold PC and IF/ID this cycle
//   stall_count            saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              mem_regwrite,
  input  logic [REG_W-1:0]  mem_wreg,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic load_use;
  logic jr_hazard;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .id_regdst    (id_ctrl[CTRL_REGDST]),
    .id_memwrite  (id_ctrl[CTRL_MEMWRITE]),
    .id_branch_eq (id_ctrl[CTRL_BRANCHEQ]),
    .id_branch_ne (id_ctrl[CTRL_BRANCHNE]),
    .id_jump      (id_ctrl[CTRL_JUMP]),
    .id_jal       (id_ctrl[CTRL_JAL]),
    .id_jr        (id_ctrl[CTRL_JR]),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_valid     (ex_valid),
    .ex_regdst    (ex_ctrl[CTRL_REGDST]),
    .ex_regwrite  (ex_ctrl[CTRL_REGWRITE]),
    .ex_memread   (ex_ctrl[CTRL_MEMREAD]),
    .ex_jal       (ex_ctrl[CTRL_JAL]),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .load_use     (load_use),
    .jr_hazard    (jr_hazard)
  );

  // A flush wins over a hazard so the wrong-path instruction is dropped
  // instead of stalled; gating with reset keeps stall low while in reset.
  assign stall = reset && id_valid && !flush && (load_use || jr_hazard);

  // Flush, stall and an empty ID slot all place a fully zeroed bubble in EX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (flush || stall || !id_valid) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else begin
      ex_valid <= 1'b1;
      ex_ctrl  <= id_ctrl;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt;

  // Counts every stalled cycle and sticks at all-ones; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios (reset, load-use,
// no false hazards, jr stalls, flush priority, stall counter) followed by
// randomized traffic, all compared against a behavioural model of the stage.
// Honours STALL_COUNTER_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control bundle fields, MSB first
  localparam logic [14:0] C_REGDST   = 15'h4000;
  localparam logic [14:0] C_ALUSRC   = 15'h2000;
  localparam logic [14:0] C_MEMTOREG = 15'h1000;
  localparam logic [14:0] C_REGWRITE = 15'h0800;
  localparam logic [14:0] C_MEMREAD  = 15'h0400;
  localparam logic [14:0] C_MEMWRITE = 15'h0200;
  localparam logic [14:0] C_BNE      = 15'h0100;
  localparam logic [14:0] C_BEQ      = 15'h0080;
  localparam logic [14:0] C_JUMP     = 15'h0040;
  localparam logic [14:0] C_JAL      = 15'h0020;
  localparam logic [14:0] C_JR       = 15'h0010;

  localparam logic [14:0] OP_ADDI = C_ALUSRC | C_REGWRITE | 15'd1;
  localparam logic [14:0] OP_LW   = C_ALUSRC | C_MEMTOREG | C_REGWRITE | C_MEMREAD | 15'd6;
  localparam logic [14:0] OP_ADD  = C_REGDST | C_REGWRITE | 15'd15;
  localparam logic [14:0] OP_J    = C_JUMP | 15'd9;
  localparam logic [14:0] OP_JR   = C_JR;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              id_valid = 1'b0;
  logic [14:0]       id_ctrl = '0;
  logic [DATA_W-1:0] id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [REG_W-1:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic              mem_regwrite = 1'b0;
  logic [REG_W-1:0]  mem_wreg = '0;
  logic              ex_valid;
  logic [14:0]       ex_ctrl;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  id_ex_stage #(
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ctrl     (id_ctrl),
    .id_pc4      (id_pc4),
    .id_rd1      (id_rd1),
    .id_rd2      (id_rd2),
    .id_imm      (id_imm),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .mem_regwrite(mem_regwrite),
    .mem_wreg    (mem_wreg),
    .ex_valid    (ex_valid),
    .ex_ctrl     (ex_ctrl),
    .ex_pc4      (ex_pc4),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Expected contents of the EX stage as a whole instruction record
  typedef struct {
    bit          valid;
    logic [14:0] ctrl;
    logic [31:0] pc4, rd1, rd2, imm;
    int          rs, rt, rd;
  } ex_rec_t;

  ex_rec_t m;
  bit      m_data_known;
  int      m_count;
  bit      obs_stall;
  int      checks = 0;
  int      errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Destination the EX instruction will write
  function automatic int ex_dest();
    if ((m.ctrl & C_REGDST) != 0) return m.rd;
    if ((m.ctrl & C_JAL) != 0) return 31;
    return m.rt;
  endfunction

  function automatic bit model_stall();
    bit reads_rs, reads_rt, lu, jr;
    int rs, rt;
    rs = int'(id_rs);
    rt = int'(id_rt);
    reads_rs = (id_ctrl & (C_JUMP | C_JAL)) == 0;
    reads_rt = (id_ctrl & (C_REGDST | C_MEMWRITE | C_BEQ | C_BNE)) != 0;
    lu = m.valid && ((m.ctrl & C_MEMREAD) != 0) && m.rt != 0 &&
         ((reads_rs && m.rt == rs) || (reads_rt && m.rt == rt));
    jr = ((id_ctrl & C_JR) != 0) && rs != 0 &&
         ((m.valid && ((m.ctrl & C_REGWRITE) != 0) && ex_dest() == rs) ||
          (mem_regwrite && int'(mem_wreg) == rs));
    return reset && id_valid && !flush && (lu || jr);
  endfunction

  function automatic void model_reset();
    m = '{default: 0};
    m_data_known = 1'b1;
    m_count = 0;
  endfunction

  function automatic void model_edge(input bit stalled);
    if (flush || stalled) begin
      m = '{default: 0};
      m_data_known = 1'b1;
    end else if (id_valid) begin
      m.valid = 1'b1;
      m.ctrl = id_ctrl;
      m.pc4 = id_pc4; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
      m.rs = int'(id_rs); m.rt = int'(id_rt); m.rd = int'(id_rd);
      m_data_known = 1'b1;
    end else begin
      m = '{default: 0};
      m_data_known = 1'b0;
    end
`ifdef STALL_COUNTER_EN
    if (stalled && m_count < CNT_MAX) m_count++;
`endif
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    checkOutput({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m.ctrl));
    checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(m_count));
    if (m_data_known) begin
      checkOutput({tag, ".ex_pc4"}, ex_pc4, m.pc4);
      checkOutput({tag, ".ex_rd1"}, ex_rd1, m.rd1);
      checkOutput({tag, ".ex_rd2"}, ex_rd2, m.rd2);
      checkOutput({tag, ".ex_imm"}, ex_imm, m.imm);
      checkOutput({tag, ".ex_rs"}, 32'(ex_rs), 32'(m.rs));
      checkOutput({tag, ".ex_rt"}, 32'(ex_rt), 32'(m.rt));
      checkOutput({tag, ".ex_rd"}, 32'(ex_rd), 32'(m.rd));
    end
  endtask

  // Called with clk low after inputs are set; returns at the next falling edge
  task automatic applyStimulus(input string tag);
    bit expected_stall;
    #1;
    expected_stall = model_stall();
    obs_stall = stall;
    checkOutput({tag, ".stall"}, 32'(stall), 32'(expected_stall));
    @(posedge clk);
    model_edge(expected_stall);
    #1;
    checkState(tag);
    @(negedge clk);
  endtask

  task automatic setId(input logic [14:0] ctrl, input int rs, input int rt, input int rd);
    id_valid = 1'b1;
    id_ctrl = ctrl;
    id_rs = REG_W'(rs);
    id_rt = REG_W'(rt);
    id_rd = REG_W'(rd);
    id_pc4 = $urandom;
    id_rd1 = $urandom;
    id_rd2 = $urandom;
    id_imm = $urandom;
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    model_reset();
    checkState("reset_pulse");
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [REG_W-1:0] pickReg();
    case ($urandom_range(0, 3))
      0: return REG_W'(0);
      1: return REG_W'(8);
      2: return REG_W'(9);
      default: return REG_W'(31);
    endcase
  endfunction

  initial begin
    // Power-on reset
    #1 reset = 1'b0;
    #1;
    model_reset();
    checkState("por");
    checkOutput("por.stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted mid-cycle with a valid instruction in ID
    setId(OP_ADDI, 0, 31, 0);
    applyStimulus("pre_rst");
    setId(OP_LW, 29, 8, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_mid.ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_mid.ex_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rst_mid.stall_count", 32'(stall_count), 32'd0);
    checkOutput("rst_mid.stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    setId(OP_ADDI, 0, 5, 0);
    applyStimulus("rst_addi");
    checkOutput("rst_addi.loaded", 32'(ex_ctrl), 32'(OP_ADDI));

    // Load-use: lw $8 then add $9,$8,$10
    setId(OP_LW, 29, 8, 0);
    applyStimulus("lu_lw");
    setId(OP_ADD, 8, 10, 9);
    applyStimulus("lu_c1");
    checkOutput("lu.stall_c1", 32'(obs_stall), 32'd1);
    checkOutput("lu.bubble", 32'(ex_valid), 32'd0);
    applyStimulus("lu_c2");
    checkOutput("lu.stall_c2", 32'(obs_stall), 32'd0);
    checkOutput("lu.add_in_ex", 32'(ex_ctrl), 32'(OP_ADD));

    // No false hazards: lw $0 with rs=0, and lw $8 with j in ID
    setId(OP_LW, 29, 0, 0);
    applyStimulus("nf_lw0");
    setId(OP_ADD, 0, 0, 9);
    applyStimulus("nf_r0");
    checkOutput("nf.r0_stall", 32'(obs_stall), 32'd0);
    setId(OP_LW, 29, 8, 0);
    applyStimulus("nf_lw8");
    setId(OP_J, 8, 8, 0);
    applyStimulus("nf_j");
    checkOutput("nf.j_stall", 32'(obs_stall), 32'd0);

    // jr with producer in EX: stalls while it sits in EX and then MEM
    setId(OP_ADDI, 0, 31, 0);
    applyStimulus("jr_addi");
    setId(OP_JR, 31, 0, 0);
    applyStimulus("jr_c1");
    checkOutput("jr.stall_c1", 32'(obs_stall), 32'd1);
    mem_regwrite = 1'b1;
    mem_wreg = 5'd31;
    applyStimulus("jr_c2");
    checkOutput("jr.stall_c2", 32'(obs_stall), 32'd1);
    mem_regwrite = 1'b0;
    applyStimulus("jr_c3");
    checkOutput("jr.stall_c3", 32'(obs_stall), 32'd0);
    checkOutput("jr.loaded", 32'(ex_ctrl), 32'(OP_JR));

    // jr with producer only in MEM: one cycle
    setId(OP_ADD, 1, 2, 3);
    applyStimulus("jrm_add");
    mem_regwrite = 1'b1;
    mem_wreg = 5'd31;
    setId(OP_JR, 31, 0, 0);
    applyStimulus("jrm_c1");
    checkOutput("jrm.stall_c1", 32'(obs_stall), 32'd1);
    mem_wreg = 5'd3;
    applyStimulus("jrm_c2");
    checkOutput("jrm.stall_c2", 32'(obs_stall), 32'd0);
    mem_regwrite = 1'b0;

    // Flush beats a simultaneous load-use hazard
    setId(OP_LW, 29, 8, 0);
    applyStimulus("fl_lw");
    setId(OP_ADD, 8, 10, 9);
    flush = 1'b1;
    applyStimulus("fl_c1");
    checkOutput("fl.stall", 32'(obs_stall), 32'd0);
    checkOutput("fl.ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("fl.ex_ctrl", 32'(ex_ctrl), 32'd0);
    flush = 1'b0;

    // Five consecutive stall cycles from a held MEM producer
    pulseReset();
    mem_regwrite = 1'b1;
    mem_wreg = 5'd31;
    setId(OP_JR, 31, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      int want;
`ifdef STALL_COUNTER_EN
      want = (k < CNT_MAX) ? k : CNT_MAX;
`else
      want = 0;
`endif
      applyStimulus("cnt");
      checkOutput($sformatf("cnt.seq%0d", k), 32'(stall_count), 32'(want));
    end
    mem_regwrite = 1'b0;
    id_valid = 1'b0;
    applyStimulus("cnt_drain");

    // Randomized traffic; ID is held steady while stalled
    for (int i = 0; i < 400; i++) begin
      if (!obs_stall) begin
        id_valid = ($urandom_range(0, 3) != 0);
        id_ctrl = 15'($urandom);
        id_rs = pickReg();
        id_rt = pickReg();
        id_rd = pickReg();
        id_pc4 = $urandom;
        id_rd1 = $urandom;
        id_rd2 = $urandom;
        id_imm = $urandom;
      end
      flush = ($urandom_range(0, 7) == 0);
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_wreg = pickReg();
      applyStimulus("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
